// File: rtl/scarv_ccx_pkg.sv
// Shared route-tag type and address decode helper for the CCX router.
// Tag is sized for the largest supported NT (8); MSB set means NONE.
package scarv_ccx_pkg;

  localparam int SCARV_CCX_NT_MAX = 8;
  localparam int SCARV_CCX_TAG_W  = $clog2(SCARV_CCX_NT_MAX) + 1;

  typedef logic [SCARV_CCX_TAG_W-1:0] scarv_ccx_tag_t;

  localparam scarv_ccx_tag_t SCARV_CCX_TAG_NONE =
    scarv_ccx_tag_t'(1 << (SCARV_CCX_TAG_W - 1));

  // Region hit for a power-of-two sized, size-aligned window.
  function automatic logic scarv_ccx_hit(
    input logic [63:0] addr,
    input logic [63:0] base,
    input logic [63:0] size
  );
    return (addr & ~(size - 64'd1)) == base;
  endfunction

endpackage

// File: rtl/scarv_ccx_route_fifo.sv
// Route-tag FIFO: remembers the target of each granted request so that
// responses are steered back in issue order.
module scarv_ccx_route_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             g_clk,
  input  logic             g_reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Tag storage; contents need no reset since count gates visibility.
  always_ff @(posedge g_clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/scarv_ccx_ic_router_nt.sv
// One-requestor to NT-target router with in-order response steering.
// Define SCARV_CCX_ROUTER_WPROT_EN to reject writes to TGT_RO targets.
module scarv_ccx_ic_router_nt
  import scarv_ccx_pkg::*;
#(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int NT    = 4,
  parameter int DEPTH = 2,
  parameter logic [NT*AW-1:0] TGT_BASE = {(NT*AW){1'b0}},
  parameter logic [NT*AW-1:0] TGT_SIZE = {NT{AW'(32'h400)}},
  parameter logic [NT-1:0]    TGT_RO   = {NT{1'b0}}
) (
  input  logic             g_clk,
  input  logic             g_reset,
  input  logic             core_req,
  output logic             core_gnt,
  input  logic             core_wen,
  input  logic [DW/8-1:0]  core_strb,
  input  logic [AW-1:0]    core_addr,
  input  logic [DW-1:0]    core_wdata,
  output logic             core_rsp,
  output logic             core_error,
  output logic [DW-1:0]    core_rdata,
  output logic [NT-1:0]    tgt_req,
  input  logic [NT-1:0]    tgt_gnt,
  output logic             tgt_wen,
  output logic [DW/8-1:0]  tgt_strb,
  output logic [AW-1:0]    tgt_addr,
  output logic [DW-1:0]    tgt_wdata,
  input  logic [NT-1:0]    tgt_rsp,
  input  logic [NT-1:0]    tgt_error,
  input  logic [NT*DW-1:0] tgt_rdata
);

  localparam int TW = SCARV_CCX_TAG_W;
  localparam int IW = TW - 1;

`ifdef SCARV_CCX_ROUTER_WPROT_EN
  localparam logic WPROT = 1'b1;
`else
  localparam logic WPROT = 1'b0;
`endif

  logic [NT-1:0]  hit;
  logic [NT-1:0]  sel;
  logic [IW-1:0]  sel_idx;
  logic           mapped;
  logic           blocked;
  logic           fwd;
  logic           full;
  logic           empty;
  logic           push;
  scarv_ccx_tag_t push_tag;
  scarv_ccx_tag_t head;

  // Table decode with lowest-index priority on overlapping regions.
  always_comb begin
    hit     = '0;
    sel     = '0;
    sel_idx = '0;
    mapped  = 1'b0;
    for (int i = 0; i < NT; i++) begin
      hit[i] = scarv_ccx_hit(64'(core_addr),
                             64'(TGT_BASE[i*AW +: AW]),
                             64'(TGT_SIZE[i*AW +: AW]));
    end
    for (int i = NT - 1; i >= 0; i--) begin
      if (hit[i]) begin
        sel     = NT'(1) << i;
        sel_idx = IW'(i);
        mapped  = 1'b1;
      end
    end
  end

  // Protected writes are handled exactly like unmapped accesses.
  always_comb begin
    blocked  = WPROT & core_wen & |(TGT_RO & sel);
    fwd      = mapped & ~blocked;
    tgt_req  = {NT{core_req & fwd & ~full}} & sel;
    core_gnt = core_req & ~full & (fwd ? |(tgt_gnt & sel) : 1'b1);
    push     = core_req & core_gnt;
    push_tag = fwd ? {1'b0, sel_idx} : SCARV_CCX_TAG_NONE;
  end

  assign tgt_wen   = core_wen;
  assign tgt_strb  = core_strb;
  assign tgt_addr  = core_addr;
  assign tgt_wdata = core_wdata;

  // Steer the head target's response; NONE answers with an error at once.
  always_comb begin
    core_rsp   = 1'b0;
    core_error = 1'b0;
    core_rdata = '0;
    if (!empty) begin
      if (head[IW]) begin
        core_rsp   = 1'b1;
        core_error = 1'b1;
      end else begin
        for (int i = 0; i < NT; i++) begin
          if (head[IW-1:0] == IW'(i)) begin
            core_rsp   = tgt_rsp[i];
            core_error = tgt_error[i];
            core_rdata = tgt_rdata[i*DW +: DW];
          end
        end
      end
    end
  end

  scarv_ccx_route_fifo #(
    .WIDTH (TW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .g_clk   (g_clk),
    .g_reset (g_reset),
    .push    (push),
    .pop     (core_rsp),
    .din     (push_tag),
    .full    (full),
    .empty   (empty),
    .head    (head)
  );

endmodule
